load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data_memory port: takes load/store requests from the core datapath and drives
//  the word-addressed memory (comb read, sync write, single we). Performs byte/half extraction with
//  sign/zero extension for loads, and read-modify-write for SB/SH since the memory has no byte enables.
// PARAMETERS
//  P_ADDR_WIDTH  11  memory word-address width (must match data_memory)
//  P_DATA_WIDTH  32  data width; the unit supports 32 only
// PORTS
//  i_clk        in   1    clock
//  i_rst        in   1    synchronous reset, active-high
//  i_req        in   1    core request valid
//  o_ready      out  1    unit can accept a request (state IDLE)
//  i_we         in   1    1=store, 0=load
//  i_funct3     in   3    RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_addr       in   32   byte address
//  i_wdata      in   32   store data (low bits used for SB/SH)
//  o_valid      out  1    one-cycle completion pulse
//  o_rdata      out  32   load result, held until next completion
//  o_err        out  1    qualified by o_valid: illegal funct3 (or misaligned, see CONFIGURATION)
//  o_mem_we     out  1    to data_memory i_we
//  o_mem_addr   out  P_ADDR_WIDTH  word address = addr_q[P_ADDR_WIDTH+1:2]
//  o_mem_wdata  out  32   to data_memory i_wdata
//  i_mem_rdata  in   32   from data_memory o_rdata (combinational)
// BEHAVIOUR
//  - Reset: state IDLE; o_valid=0, o_err=0, o_rdata=0, addr_q/wdata_q/merge_q=0; o_mem_we=0 while i_rst=1.
//  - FSM: IDLE -> ACCESS -> [WRITE] -> RESP -> IDLE.
//  - IDLE: o_ready=1; on i_req latch i_we, i_funct3, i_addr, i_wdata; go ACCESS. i_req when not IDLE ignored.
//  - ACCESS: o_mem_addr from addr_q. Load: lane = addr_q[1:0] (B) / addr_q[1] (H); extend per funct3,
//    register into o_rdata; go RESP. SW: o_mem_we=1, o_mem_wdata=wdata_q; go RESP.
//    SB/SH: merge_q <= i_mem_rdata with selected byte/half lane replaced; go WRITE.
//  - WRITE: o_mem_we=1, o_mem_wdata=merge_q; go RESP.
//  - RESP: o_valid=1 for exactly one cycle, o_err per check; go IDLE (o_ready=1 next cycle).
//  - Latency (accept edge = cycle 0): load/SW o_valid at cycle 2; SB/SH at cycle 3. Back-to-back
//    throughput: one request per 3 (or 4) cycles.
//  - o_mem_we asserted only in ACCESS(SW) and WRITE, never in IDLE/RESP; at most one write per request.
//  - Illegal funct3 (011, 110, 111, or 1xx with i_we=1): no memory write, o_rdata unchanged,
//    o_valid=1 with o_err=1 at cycle 2.
//  - Address bits above P_ADDR_WIDTH+1 ignored (wrap modulo memory size).
//  - Reset mid-operation: abort; any WRITE/ACCESS-store coincident with i_rst is suppressed; no o_valid.
//  - o_rdata: sign extension from bit 7/15 for B/H; zero extension for BU/HU.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]!=0 or W with addr[1:0]!=0 -> no memory write, o_rdata
//    unchanged, o_valid with o_err=1 at cycle 2.
//  Not defined: low address bits beyond access size are ignored (H uses addr[1], W uses word); no error.
// STRUCTURE
//  lsu_pkg: funct3 width enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state enum (IDLE, ACCESS, WRITE, RESP),
//    localparam LSU_DATA_W=32.
//  Sub-module lsu_align (combinational): load extract/extend and store lane merge; used in ACCESS.
// TESTING
//  - SW 0xDEADBEEF @0x10, then LW @0x10 -> mem[4]=0xDEADBEEF written at cycle 1, o_rdata=0xDEADBEEF at cycle 2.
//  - mem[4]=0x11223344; SB 0xAA @0x12 -> one write at cycle 2 of 0x11AA3344, o_valid at cycle 3.
//  - mem[4]=0x8000F07F; LB @0x10 -> 0x0000007F; LB @0x11 -> 0xFFFFFFF0; LHU @0x12 -> 0x00008000; LH @0x12 -> 0xFFFF8000.
//  - Illegal funct3=011 load and funct3=100 store -> o_err=1, no o_mem_we pulse, o_rdata unchanged.
//  - i_rst asserted during WRITE of SH -> memory unchanged, no o_valid, o_ready=1 after release.
//  - LSU_MISALIGN_TRAP_EN: LW @0x13 -> o_err=1, no write on SW @0x13; undefined: SW @0x13 writes mem[4].

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_width_e  RV32I load/store width codes (funct3)
//   lsu_state_e  sequencer states of load_store_unit
//   LSU_DATA_W   datapath width supported by the unit
//   lsu_funct3_legal()  funct3 legality for a load or a store
package lsu_pkg;

    localparam int LSU_DATA_W = 32;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_width_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Unsigned widths only exist for loads; a store with 1xx is illegal.
    function automatic logic lsu_funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            LSU_B, LSU_H, LSU_W: ok = 1'b1;
            LSU_BU, LSU_HU:      ok = !is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   funct3     in   width code of the access
//   byte_off   in   low two bits of the byte address
//   mem_rdata  in   word currently read from memory
//   wdata      in   low half of the store data (SB uses [7:0], SH uses [15:0])
//   load_data  out  selected byte/half/word, sign- or zero-extended
//   merge_data out  mem_rdata with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_off,
    input  logic [LSU_DATA_W-1:0] mem_rdata,
    input  logic [15:0]           wdata,
    output logic [LSU_DATA_W-1:0] load_data,
    output logic [LSU_DATA_W-1:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = mem_rdata[{byte_off, 3'b000} +: 8];
        // Half lane follows addr[1] only; addr[0] is ignored here.
        half_sel  = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3)
            LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  load_data = {24'd0, byte_sel};
            LSU_HU:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase

        merge_data = mem_rdata;
        if (funct3 == LSU_H) begin
            if (byte_off[1]) merge_data[31:16] = wdata;
            else             merge_data[15:0]  = wdata;
        end else begin
            merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of a word-addressed data memory (combinational
// read, synchronous write, no byte enables). Loads are extracted and extended;
// SB/SH are done as read-modify-write.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req / o_ready         request handshake (accepted only while idle)
//   i_we, i_funct3          store flag and RV32I width code
//   i_addr, i_wdata         byte address and store data
//   o_valid, o_rdata, o_err one-cycle completion pulse, load result (held), error flag
//   o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_rdata  memory port
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned H/HU/W accesses report
// o_err instead of silently ignoring the low address bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 11,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    output logic                    o_ready,
    input  logic                    i_we,
    input  logic [2:0]              i_funct3,
    input  logic [31:0]             i_addr,
    input  logic [P_DATA_WIDTH-1:0] i_wdata,
    output logic                    o_valid,
    output logic [P_DATA_WIDTH-1:0] o_rdata,
    output logic                    o_err,
    output logic                    o_mem_we,
    output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int AQ_W = P_ADDR_WIDTH + 2;

    lsu_state_e              state;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [AQ_W-1:0]         addr_q;
    logic [P_DATA_WIDTH-1:0] wdata_q;
    logic [P_DATA_WIDTH-1:0] merge_q;

    logic [P_DATA_WIDTH-1:0] load_data;
    logic [P_DATA_WIDTH-1:0] merge_data;
    logic                    misalign;
    logic                    access_err;
    logic                    sw_write;

    // Byte-address bits above the memory range wrap; they are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, i_addr[31:AQ_W]};

    lsu_align u_align (
        .funct3     (funct3_q),
        .byte_off   (addr_q[1:0]),
        .mem_rdata  (i_mem_rdata),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0]==01 covers both H and HU.
    assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q == LSU_W) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign access_err = !lsu_funct3_legal(funct3_q, we_q) || misalign;
    assign sw_write   = we_q && (funct3_q == LSU_W) && !access_err;

    assign o_ready     = (state == IDLE);
    assign o_mem_addr  = addr_q[AQ_W-1:2];
    assign o_mem_wdata = (state == WRITE) ? merge_q : wdata_q;
    // Gated by reset so a write in flight when reset hits never lands.
    assign o_mem_we    = !i_rst && (((state == ACCESS) && sw_write) || (state == WRITE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_rdata  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        we_q     <= i_we;
                        funct3_q <= i_funct3;
                        addr_q   <= i_addr[AQ_W-1:0];
                        wdata_q  <= i_wdata;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (access_err) begin
                        o_valid <= 1'b1;
                        o_err   <= 1'b1;
                        state   <= RESP;
                    end else if (!we_q) begin
                        o_rdata <= load_data;
                        o_valid <= 1'b1;
                        state   <= RESP;
                    end else if (funct3_q == LSU_W) begin
                        o_valid <= 1'b1;
                        state   <= RESP;
                    end else begin
                        merge_q <= merge_data;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    o_valid <= 1'b1;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst, i_req, i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_ready, o_valid, o_err, o_mem_we;
    logic [31:0] o_rdata, o_mem_wdata, i_mem_rdata;
    logic [10:0] o_mem_addr;

    logic [31:0] mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int cyc = 0, wr_cnt = 0, wr_cyc = 0;
    int n_cmp = 0, n_bad = 0;

    always #5 i_clk = ~i_clk;

    load_store_unit #(.P_ADDR_WIDTH(11), .P_DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ready(o_ready),
        .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_valid(o_valid), .o_rdata(o_rdata), .o_err(o_err),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata)
    );

    // Memory model: combinational read, synchronous write; bench preload port.
    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        @(negedge i_clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge i_clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request; lat = index of the edge at which o_valid is captured
    // (accept edge = 0), 0 if it never came. acc = accept edge number.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output int acc);
        int k;
        k = 0;
        @(negedge i_clk);
        while (!o_ready && k < 10) begin @(negedge i_clk); k++; end
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        @(posedge i_clk); #1;
        acc = cyc - 1;
        i_req = 1'b0;
        lat = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge i_clk);
            if (o_valid) begin lat = j; break; end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000; i_addr = '0; i_wdata = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
        n_cmp++; if (o_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
        n_cmp++; if (o_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", o_mem_we); end
        i_rst = 1'b0;
    endtask

    task automatic test_word();
        int lat, acc, w0;
        w0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, acc);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sw_writes: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_cyc - acc !== 1) begin n_bad++; $display("FAIL sw_write_cycle: got %0d want 1", wr_cyc - acc); end
        n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b want 0", o_err); end
        w0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, acc);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_cmp++; if (o_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata); end
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL lw_writes: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_sub_store();
        int lat, acc, w0;
        preload(11'd4, 32'h11223344);
        w0 = wr_cnt;
        do_req(1'b1, 3'b000, 32'h12, 32'hFFFFFFAA, lat, acc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sb_writes: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_cyc - acc !== 2) begin n_bad++; $display("FAIL sb_write_cycle: got %0d want 2", wr_cyc - acc); end
        n_cmp++; if (mem[4] !== 32'h11AA3344) begin n_bad++; $display("FAIL sb_mem: got %h want 11aa3344", mem[4]); end
        do_req(1'b1, 3'b001, 32'h12, 32'h1234BEEF, lat, acc);
        n_cmp++; if (mem[4] !== 32'hBEEF3344) begin n_bad++; $display("FAIL sh_hi_mem: got %h want beef3344", mem[4]); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
        do_req(1'b1, 3'b000, 32'h13, 32'h0000005A, lat, acc);
        n_cmp++; if (mem[4] !== 32'h5AEF3344) begin n_bad++; $display("FAIL sb_b3_mem: got %h want 5aef3344", mem[4]); end
        do_req(1'b1, 3'b001, 32'h10, 32'h00009876, lat, acc);
        n_cmp++; if (mem[4] !== 32'h5AEF9876) begin n_bad++; $display("FAIL sh_lo_mem: got %h want 5aef9876", mem[4]); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [7] = '{3'b000, 3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
        logic [31:0] ad  [7] = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h12, 32'h13, 32'h10};
        logic [31:0] exp [7] = '{32'h0000007F, 32'hFFFFFFF0, 32'h000000F0, 32'h00008000,
                                 32'hFFFF8000, 32'hFFFFFF80, 32'hFFFFF07F};
        int lat, acc;
        preload(11'd4, 32'h8000F07F);
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0, lat, acc);
            n_cmp++;
            if (o_rdata !== exp[i] || lat !== 2 || o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL load_ext[%0d]: got rdata=%h lat=%0d err=%b want rdata=%h lat=2 err=0",
                         i, o_rdata, lat, o_err, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int lat, acc, w0;
        logic [31:0] held;
        held = o_rdata;
        w0 = wr_cnt;
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b1 || lat !== 2) begin n_bad++; $display("FAIL illegal_load: got err=%b lat=%0d want err=1 lat=2", o_err, lat); end
        n_cmp++; if (o_rdata !== held) begin n_bad++; $display("FAIL illegal_load_rdata: got %h want %h", o_rdata, held); end
        do_req(1'b1, 3'b100, 32'h10, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b1 || lat !== 2) begin n_bad++; $display("FAIL illegal_store_bu: got err=%b lat=%0d want err=1 lat=2", o_err, lat); end
        do_req(1'b1, 3'b110, 32'h10, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL illegal_store_110: got err=%b want 1", o_err); end
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL illegal_writes: got %0d want 0", wr_cnt - w0); end
        n_cmp++; if (mem[4] !== 32'h8000F07F) begin n_bad++; $display("FAIL illegal_mem: got %h want 8000f07f", mem[4]); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'h8000F07F) begin n_bad++; $display("FAIL after_illegal: got err=%b rdata=%h want err=0 rdata=8000f07f", o_err, o_rdata); end
    endtask

    task automatic test_reset_mid();
        int w0, seen;
        preload(11'd8, 32'h55667788);
        w0 = wr_cnt;
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'h22; i_wdata = 32'h0000ABCD;
        @(posedge i_clk); #1;   // accepted, now ACCESS
        i_req = 1'b0;
        @(posedge i_clk); #1;   // now WRITE
        i_rst = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_mem_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem_we: got %b want 0", o_mem_we); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_valid: got %0d pulses want 0", seen); end
        n_cmp++; if (mem[8] !== 32'h55667788 || wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL rstmid_mem: got %h writes=%0d want 55667788 writes=0", mem[8], wr_cnt - w0); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_wrap_and_busy();
        int lat, acc, w0;
        preload(11'd16, 32'h00000000);
        do_req(1'b1, 3'b010, 32'h00002010, 32'h0BADF00D, lat, acc);
        n_cmp++; if (mem[4] !== 32'h0BADF00D) begin n_bad++; $display("FAIL wrap_store: got %h want 0badf00d", mem[4]); end
        do_req(1'b0, 3'b010, 32'hFFFFE010, 32'h0, lat, acc);
        n_cmp++; if (o_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL wrap_load: got %h want 0badf00d", o_rdata); end
        // A request raised while busy must be ignored.
        w0 = wr_cnt;
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h20; i_wdata = 32'h77;
        @(posedge i_clk); #1;
        i_funct3 = 3'b010; i_addr = 32'h40; i_wdata = 32'hFFFFFFFF;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (mem[16] !== 32'h0 || wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL busy_ignore: got mem16=%h writes=%0d want 0 writes=1", mem[16], wr_cnt - w0); end
        n_cmp++; if (mem[8][7:0] !== 8'h77) begin n_bad++; $display("FAIL busy_first: got %h want xxxxxx77", mem[8]); end
    endtask

    task automatic test_back_to_back();
        int lat1, acc1, lat2, acc2;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat1, acc1);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, lat2, acc2);
        n_cmp++; if (acc2 - acc1 !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 3", acc2 - acc1); end
        n_cmp++; if (o_rdata !== 32'h0000000B || lat2 !== 2) begin n_bad++; $display("FAIL b2b_second: got %h lat=%0d want 0000000b lat=2", o_rdata, lat2); end
    endtask

    task automatic test_misalign();
        int lat, acc, w0;
`ifdef LSU_MISALIGN_TRAP_EN
        logic [31:0] held;
        preload(11'd4, 32'h00000000);
        held = o_rdata;
        w0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'h13, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b1 || lat !== 2 || o_rdata !== held) begin n_bad++; $display("FAIL mis_lw: got err=%b lat=%0d rdata=%h want err=1 lat=2 rdata=%h", o_err, lat, o_rdata, held); end
        do_req(1'b1, 3'b010, 32'h13, 32'hCAFEF00D, lat, acc);
        n_cmp++; if (o_err !== 1'b1 || wr_cnt - w0 !== 0 || mem[4] !== 32'h0) begin n_bad++; $display("FAIL mis_sw: got err=%b writes=%0d mem=%h want err=1 writes=0 mem=0", o_err, wr_cnt - w0, mem[4]); end
        do_req(1'b0, 3'b001, 32'h11, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL mis_lh: got err=%b want 1", o_err); end
`else
        w0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'h13, 32'hCAFEF00D, lat, acc);
        n_cmp++; if (o_err !== 1'b0 || wr_cnt - w0 !== 1 || mem[4] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mis_sw: got err=%b writes=%0d mem=%h want err=0 writes=1 mem=cafef00d", o_err, wr_cnt - w0, mem[4]); end
        do_req(1'b0, 3'b010, 32'h13, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mis_lw: got err=%b rdata=%h want err=0 rdata=cafef00d", o_err, o_rdata); end
        do_req(1'b0, 3'b001, 32'h11, 32'h0, lat, acc);
        n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'hFFFFF00D) begin n_bad++; $display("FAIL mis_lh: got err=%b rdata=%h want err=0 rdata=fffff00d", o_err, o_rdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_sub_store();
        test_load_ext();
        test_illegal();
        test_reset_mid();
        test_wrap_and_busy();
        preload(11'd4, 32'h0B000000);
        test_back_to_back();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
